// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store memory master: access sizes and FSM states.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane steering: extracts and extends load data from a memory word,
// and builds the merged word for sub-word stores (read-modify-write).
module lsu_lane_align
  import lsu_pkg::*;
(
  input  size_t       size,
  input  logic        sign_ext,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte and half lanes; a half uses addr_lo[1] only.
  always_comb begin
    byte_sel = mem_word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
  end

  // Extend the selected lane for loads; words pass straight through.
  always_comb begin
    load_data = mem_word;
    case (size)
      SZ_BYTE: load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: load_data = mem_word;
    endcase
  end

  // Replace only the addressed lane, keeping the other bytes of the word.
  always_comb begin
    merged_word = mem_word;
    case (size)
      SZ_BYTE: merged_word[{addr_lo, 3'b000} +: 8] = store_data[7:0];
      SZ_HALF: begin
        if (addr_lo[1]) merged_word[31:16] = store_data[15:0];
        else            merged_word[15:0]  = store_data[15:0];
      end
      default: merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-organised data memory. Sub-word stores are
// done as read-modify-write. Optional macro LSU_ALIGN_CHECK_EN turns
// misaligned half/word accesses into errors; without it they use the
// half lane addr[1] / ignore addr[1:0] for words.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            state_reg, state_next;
  logic              write_reg;
  size_t             size_reg;
  logic              sign_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       merged_reg;
  logic [31:0]       rdata_reg;
  logic              err_reg;

  logic              accept;
  logic              req_err;
  logic              align_err;
  logic [31:0]       load_data;
  logic [31:0]       merged_word;

  // Classify an incoming request as erroneous (reserved size, out of range, misaligned).
  always_comb begin
`ifdef LSU_ALIGN_CHECK_EN
    align_err = ((req_size == SZ_HALF) && req_addr[0]) ||
                ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    align_err = 1'b0;
`endif
    req_err = (req_size == SZ_RSVD) || (|req_addr[ADDR_W-1:MEM_AW]) || align_err;
  end

  assign accept = req_valid && (state_reg == IDLE);

  lsu_lane_align u_lane_align (
    .size        (size_reg),
    .sign_ext    (sign_reg),
    .addr_lo     (addr_reg[1:0]),
    .mem_word    (mem_rdata),
    .store_data  (wdata_reg),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and memory/handshake outputs.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                                    state_next = RESP;
          else if (req_write && (req_size == SZ_WORD))    state_next = WR;
          else                                            state_next = RD;
        end
      end
      RD: begin
        mem_read   = 1'b1;
        mem_addr   = {addr_reg[ADDR_W-1:2], 2'b00};
        state_next = write_reg ? WR : RESP;
      end
      WR: begin
        mem_write  = 1'b1;
        mem_addr   = {addr_reg[ADDR_W-1:2], 2'b00};
        mem_wdata  = (size_reg == SZ_WORD) ? wdata_reg : merged_reg;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, RMW merge buffer and response registers (updated only when entering RESP).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_reg  <= 1'b0;
      size_reg   <= SZ_BYTE;
      sign_reg   <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      merged_reg <= '0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (accept) begin
        write_reg <= req_write;
        size_reg  <= size_t'(req_size);
        sign_reg  <= req_signed;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        if (req_err) begin
          rdata_reg <= '0;
          err_reg   <= 1'b1;
        end
      end
      if (state_reg == RD) begin
        if (write_reg) begin
          merged_reg <= merged_word;
        end else begin
          rdata_reg <= load_data;
          err_reg   <= 1'b0;
        end
      end
      if (state_reg == WR) begin
        rdata_reg <= '0;
        err_reg   <= 1'b0;
      end
    end
  end

  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master against a byte-array reference model.
module tb_lsu_mem_master;

`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  // Memory attached to the DUT, plus a preload port.
  logic [31:0] mem [0:255];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;

  // Reference: flat byte array, little-endian.
  logic [7:0]  ref_b [0:1023];

  always #5 clk = ~clk;

  lsu_mem_master #(.ADDR_W(32), .MEM_AW(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (pre_en)         mem[pre_idx] <= pre_data;
    else if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
  endfunction

  task automatic preset(input int idx, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx[7:0]; pre_data = d;
    @(posedge clk);
    #1 pre_en = 1'b0;
    for (int k = 0; k < 4; k++) ref_b[4*idx+k] = d[8*k +: 8];
  endtask

  // One request: predict from the byte model, drive, watch each cycle, compare.
  task automatic run(input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd, input bit keep,
                     output logic [31:0] rd_o, output logic err_o);
    logic        e_err;
    int          e_lat, e_reads, e_writes;
    logic [31:0] e_rd, e_wword;
    int          lo, hoff, lat, nrd, nwr;
    logic [15:0] h;
    lo = int'(a[9:0]);
    hoff = int'({a[9:2], 2'b00}) + (a[1] ? 2 : 0);
    e_err = (sz == 2'd3) || (a[31:10] != 0) ||
            (ALIGN_CHK && ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 0)));
    e_rd = 32'h0; e_wword = 32'h0;
    e_reads = 0; e_writes = 0;
    if (e_err) e_lat = 1;
    else if (w && sz != 2'd2) e_lat = 3;
    else e_lat = 2;
    if (!e_err) begin
      e_reads  = (!w || sz != 2'd2) ? 1 : 0;
      e_writes = w ? 1 : 0;
      if (!w) begin
        if (sz == 2'd0) e_rd = sg ? 32'(signed'(ref_b[lo])) : {24'h0, ref_b[lo]};
        else if (sz == 2'd1) begin
          h = {ref_b[hoff+1], ref_b[hoff]};
          e_rd = sg ? 32'(signed'(h)) : {16'h0, h};
        end else e_rd = ref_word(int'(a[9:2]));
      end else begin
        if (sz == 2'd0) ref_b[lo] = wd[7:0];
        else if (sz == 2'd1) begin ref_b[hoff] = wd[7:0]; ref_b[hoff+1] = wd[15:8]; end
        else for (int k = 0; k < 4; k++) ref_b[4*int'(a[9:2])+k] = wd[8*k +: 8];
        e_wword = ref_word(int'(a[9:2]));
      end
    end

    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    chk("req_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 if (!keep) req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; rd_o = 'x; err_o = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("rd_wr_excl", {31'h0, mem_read & mem_write}, 32'h0);
      if (mem_read)  begin nrd++; chk("rd_addr", mem_addr, {a[31:2], 2'b00}); end
      if (mem_write) begin
        nwr++;
        chk("wr_addr", mem_addr, {a[31:2], 2'b00});
        chk("wr_data", mem_wdata, e_wword);
      end
      if (resp_valid) begin
        lat = c; rd_o = resp_rdata; err_o = resp_err;
        break;
      end
    end
    $display("req w=%0d sz=%0d s=%0d addr=%h wd=%h -> lat=%0d err=%0d rdata=%h",
             w, sz, sg, a, wd, lat, err_o, rd_o);
    chk("latency", 32'(lat), 32'(e_lat));
    chk("resp_err", {31'h0, err_o}, {31'h0, e_err});
    chk("resp_rdata", rd_o, e_rd);
    chk("n_reads", 32'(nrd), 32'(e_reads));
    chk("n_writes", 32'(nwr), 32'(e_writes));
    chk("mem_word", mem[a[9:2]], ref_word(int'(a[9:2])));
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) ref_b[i] = 8'h0;

    // Reset values.
    #12;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_mem_rw", {30'h0, mem_read, mem_write}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", {31'h0, resp_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 256; i++) preset(i, 32'h0);

    preset(0, 32'd10); preset(1, 32'd1); preset(4, 32'd100);
    run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, rd, er);
    chk("lw_0x10", rd, 32'd100);

    preset(0, 32'h80FF7F01);
    run(1'b0, 2'd0, 1'b1, 32'h1, 32'h0, 1'b0, rd, er); chk("lb_1", rd, 32'h0000007F);
    run(1'b0, 2'd0, 1'b1, 32'h2, 32'h0, 1'b0, rd, er); chk("lb_2", rd, 32'hFFFFFFFF);
    run(1'b0, 2'd0, 1'b0, 32'h3, 32'h0, 1'b0, rd, er); chk("lbu_3", rd, 32'h00000080);
    run(1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 1'b0, rd, er); chk("lh_2", rd, 32'hFFFF80FF);
    run(1'b0, 2'd1, 1'b0, 32'h2, 32'h0, 1'b0, rd, er); chk("lhu_2", rd, 32'h000080FF);

    run(1'b1, 2'd0, 1'b0, 32'h6, 32'hAB, 1'b0, rd, er);
    chk("sb_6_word1", mem[1], 32'h00AB0001);
    run(1'b1, 2'd1, 1'b0, 32'h4, 32'h1234, 1'b0, rd, er);
    chk("sh_4_word1", mem[1], 32'h00AB1234);

    run(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, 1'b0, rd, er);
    chk("lw_misaligned_err", {31'h0, er}, {31'h0, ALIGN_CHK});
    run(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 1'b0, rd, er);
    chk("lw_range_err", {31'h0, er}, 32'h1);

    // Reset while the RMW write is pending: memory must stay intact.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_rd", {31'h0, mem_read}, 32'h1);
    @(negedge clk);
    chk("abort_wr_pending", {31'h0, mem_write}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_wr_dropped", {31'h0, mem_write}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("abort_no_resp", {31'h0, resp_valid}, 32'h0);
      @(negedge clk);
    end
    chk("abort_word4", mem[4], 32'd100);
    chk("abort_ready", {31'h0, req_ready}, 32'h1);
    $display("reset-abort SB 0x10: word4=%0d ready=%0d", mem[4], req_ready);

    // Back-to-back with req_valid held high.
    run(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, 1'b1, rd, er);
    run(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, rd, er);
    chk("b2b_lw", rd, 32'hDEADBEEF);

    // Randomized traffic over a small window so loads hit earlier stores.
    for (int n = 0; n < 150; n++) begin
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 11) == 0) a = a | (32'h1 << $urandom_range(10, 31));
      run(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          a, $urandom, 1'b0, rd, er);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the word-organised data memory port (MemRead, MemWrite, Address, WriteData, ReadData) on behalf of the MIPS pipeline MEM stage.
- Accepts LW/LH/LHU/LB/LBU/SW/SH/SB requests through a valid/ready handshake.
- Sign/zero-extends loads; implements sub-word stores as read-modify-write because the memory writes only full words.
- Returns one response per request; the response carries an error flag.

Parameters:
- ADDR_W, 32, byte-address width of request and memory address.
- MEM_AW, 10, number of low address bits that map to memory (256 words). Any set bit above MEM_AW-1 is out of range.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block idle, can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_signed  in  1  sign-extend load (ignored for stores and words)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data (0 for stores and errors)
- resp_err  out  1  misaligned, reserved size or out-of-range
- mem_read  out  1  to MemRead
- mem_write  out  1  to MemWrite
- mem_addr  out  ADDR_W  to Address; low 2 bits always 0
- mem_wdata  out  32  to WriteData
- mem_rdata  in  32  from ReadData (combinational, valid the same cycle as mem_read)

Behaviour:
- States: IDLE, RD, WR, RESP.
- Reset (async, rst_n=0): state=IDLE. All outputs 0 except req_ready=1. Internal request registers cleared.
- req_ready = (state==IDLE). Handshake occurs when req_valid && req_ready; request fields are latched in that cycle.
- IDLE accept transitions:
  - error -> RESP.
  - load -> RD.
  - word store -> WR.
  - sub-word store -> RD.
- Error conditions:
  - req_size==3.
  - Half with addr[0]=1.
  - Word with addr[1:0]!=0.
  - Any set bit in addr[ADDR_W-1:MEM_AW].
- RD state:
  - mem_read=1, mem_addr={addr[ADDR_W-1:2],2'b00}.
  - mem_rdata is sampled at the clock edge ending RD.
  - Load: extract byte addr[1:0] / half addr[1], extend per req_signed, latch into resp_rdata, go to RESP.
  - Sub-word store: latch the merged word, go to WR. Merge replaces the addressed byte/half lane with req_wdata[7:0]/[15:0]; other lanes are unchanged.
- WR state:
  - mem_write=1, mem_addr=aligned word address.
  - mem_wdata = req_wdata for word stores, merged word for sub-word stores.
  - Next state RESP.
- RESP state: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata/resp_err hold until the next response.
- mem_read and mem_write are never both 1. Both are 0 in IDLE and RESP.
- Latency, accept edge to resp_valid:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- Back-to-back: a new request is accepted in the cycle after RESP (IDLE). Maximum throughput is one load per 3 cycles.
- Reset mid-operation:
  - Any in-flight access is abandoned and no response is issued.
  - An RMW aborted between RD and WR leaves memory unmodified.
- A store's written data is visible to a load accepted afterwards.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined: misalignment is checked as described in Behaviour.
- Undefined:
  - Misalignment is not an error. A half uses lane addr[1]; a word ignores addr[1:0].
  - Only reserved size and out-of-range set resp_err.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings: SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2, SZ_RSVD=3.
  - state encoding: IDLE, RD, WR, RESP.
- One natural combinational sub-module, lsu_lane_align:
  - Inputs: size, signed, addr[1:0], memory word, store data.
  - Outputs: extended load data and merged store word.

Test Plan:
- Memory preset word0=10, word1=1, word4=100. LW addr 0x10 -> mem_read 1 cycle at 0x10; resp_rdata=100, resp_err=0, 2 cycles after accept.
- Memory word0=0x80FF7F01:
  - LB addr 1 -> 0x0000007F.
  - LB addr 2 -> 0xFFFFFFFF.
  - LBU addr 3 -> 0x00000080.
  - LH addr 2 -> 0xFFFF80FF.
  - LHU addr 2 -> 0x000080FF.
- word1=0x00000001:
  - SB addr 6 data 0xAB -> RD then WR at 0x04 with mem_wdata=0x00AB0001.
  - Then SH addr 4 data 0x1234 -> memory word1=0x00AB1234.
- With LSU_ALIGN_CHECK_EN defined:
  - LW addr 0x02 -> resp_err=1, resp_rdata=0, no mem_read/mem_write pulse, response 1 cycle after accept.
  - LW addr 0x400 -> resp_err=1.
- SB to word4 (100) at addr 0x10 data 0x55, with rst_n pulsed low during the WR-pending cycle (after RD) -> no resp_valid, word4 still 100, req_ready=1 after release.
- Back-to-back SW 0x20=0xDEADBEEF then LW 0x20 with req_valid held high -> second accept in the cycle after the first resp_valid; resp_rdata=0xDEADBEEF.
